// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared types and defaults for the flash Wishbone arbiter
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int DATA_W_DEF         = 32;
    localparam int SEL_W              = DATA_W_DEF / 8;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/flash_arb_rr.sv
// rtl/flash_arb_rr.sv - two-way round-robin picker, one-hot result
module flash_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] pick
);

    // A lone requester wins outright; on a tie the master not served last wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/flash_wb_arbiter.sv
// rtl/flash_wb_arbiter.sv - two-master round-robin Wishbone arbiter for flash_top (optional FLASH_ARB_TIMEOUT_EN)
module flash_wb_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    output logic [1:0]          grant_o
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] burst_q, burst_d;
    logic [1:0] pick;
    logic       gnt0, gnt1;
    logic       own_cyc, other_cyc;
    logic       raw_cyc, raw_stb;
    logic       to_hit;

    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign grant_o = {gnt1, gnt0};

    flash_arb_rr u_rr (
        .req        ({m1_cyc_i, m0_cyc_i}),
        .last_grant (last_grant_q),
        .pick       (pick)
    );

    assign own_cyc   = gnt1 ? m1_cyc_i : m0_cyc_i;
    assign other_cyc = gnt1 ? m0_cyc_i : m1_cyc_i;
    assign raw_cyc   = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
    assign raw_stb   = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q, to_cnt_d;

    // Abort does not look at s_ack_i so the slave's ack path never loops back into stb.
    assign to_hit = raw_stb & (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!(gnt0 | gnt1) || !own_cyc || to_hit || s_ack_i) begin
            to_cnt_d = '0;
        end else if (raw_stb) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign to_hit         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign s_cyc_o  = raw_cyc & ~to_hit;
    assign s_stb_o  = raw_stb & ~to_hit;
    assign m0_ack_o = gnt0 & s_ack_i & ~to_hit;
    assign m1_ack_o = gnt1 & s_ack_i & ~to_hit;
    assign m0_err_o = gnt0 & to_hit;
    assign m1_err_o = gnt1 & to_hit;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt0) begin
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt1) begin
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // The burst count saturates, so a lone master keeps the grant and a late
    // competitor takes over at the very next ack.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_d      = burst_q;
        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (pick[0]) begin
                    state_d = GNT0;
                end else if (pick[1]) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc || to_hit) begin
                    state_d      = IDLE;
                    last_grant_d = gnt1;
                    burst_d      = '0;
                end else if (s_ack_i) begin
                    if (other_cyc && (burst_q == BURST_LAST)) begin
                        state_d      = IDLE;
                        last_grant_d = gnt1;
                        burst_d      = '0;
                    end else if (burst_q != BURST_LAST) begin
                        burst_d = burst_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
        end
    end

endmodule

// File: tb/tb_flash_wb_arbiter.sv
// tb/tb_flash_wb_arbiter.sv - randomized and directed checks of flash_wb_arbiter against a tenure-level model
module tb_flash_wb_arbiter;

    localparam int AW = 27;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int TO = 8;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [1:0]      grant_o;

    always #5 clk = ~clk;

    flash_wb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_100MHz(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the slave, who was served last, acks and stalls in this tenure.
    int owner, last, served, stall;
    int n_ack0, n_ack1, err_seen, step_idx;
    logic [AW-1:0] a0, a1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        last   = 1;
        served = 0;
        stall  = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_s_stb", 64'(s_stb_o), 64'd0);
        chk("rst_acks", 64'({m1_ack_o, m0_ack_o}), 64'd0);
        chk("rst_errs", 64'({m1_err_o, m0_err_o}), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input bit c0, input bit c1, input bit ack);
        bit own_c, oth_c, hit;
        m0_cyc_i = c0; m0_stb_i = c0; m0_we_i = 1'($urandom);
        m0_sel_i = 4'($urandom); m0_adr_i = a0; m0_dat_i = $urandom;
        m1_cyc_i = c1; m1_stb_i = c1; m1_we_i = 1'($urandom);
        m1_sel_i = 4'($urandom); m1_adr_i = a1; m1_dat_i = $urandom;
        s_ack_i  = ack;
        s_dat_i  = $urandom;
        #1;
        own_c = (owner == 0) ? c0 : (owner == 1) ? c1 : 1'b0;
        oth_c = (owner == 0) ? c1 : c0;
        hit   = TO_EN && (owner >= 0) && own_c && (stall == TO - 1);
        chk("grant", 64'(grant_o), (owner == 0) ? 64'd1 : (owner == 1) ? 64'd2 : 64'd0);
        chk("s_cyc", 64'(s_cyc_o), 64'(own_c && !hit));
        chk("s_stb", 64'(s_stb_o), 64'(own_c && !hit));
        chk("s_adr", 64'(s_adr_o), (owner == 0) ? 64'(a0) : (owner == 1) ? 64'(a1) : 64'd0);
        chk("s_we", 64'(s_we_o), (owner == 0) ? 64'(m0_we_i) : (owner == 1) ? 64'(m1_we_i) : 64'd0);
        chk("m0_ack", 64'(m0_ack_o), 64'(owner == 0 && ack && !hit));
        chk("m1_ack", 64'(m1_ack_o), 64'(owner == 1 && ack && !hit));
        chk("m0_err", 64'(m0_err_o), 64'(owner == 0 && hit));
        chk("m1_err", 64'(m1_err_o), 64'(owner == 1 && hit));
        chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
        step_idx++;
        if (m0_ack_o) n_ack0++;
        if (m1_ack_o) n_ack1++;
        if (m0_err_o || m1_err_o) err_seen = step_idx;
        if (owner < 0) begin
            if (c0 && c1) owner = (last == 1) ? 0 : 1;
            else if (c0) owner = 0;
            else if (c1) owner = 1;
            served = 0;
            stall  = 0;
        end else if (!own_c || hit) begin
            last   = owner;
            owner  = -1;
            served = 0;
            stall  = 0;
        end else if (ack) begin
            served++;
            stall = 0;
            if (oth_c && served >= MB) begin
                last   = owner;
                owner  = -1;
                served = 0;
            end
        end else begin
            stall++;
        end
        @(negedge clk);
    endtask

    int rem0, rem1;

    initial begin
        reset_n = 1'b1;
        {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
        m0_sel_i = '0; m1_sel_i = '0; m0_adr_i = '0; m1_adr_i = '0;
        m0_dat_i = '0; m1_dat_i = '0; s_dat_i = '0;
        a0 = 27'h0010000; a1 = 27'h0200040;
        step_idx = 0;
        #2;
        do_reset();

        // Lone m0 read at 0x10000; grant one cycle after the request.
        step(1, 0, 0);
        step(1, 0, 1);
        step(0, 0, 0);

        // Simultaneous request after reset: m0 first, one dead cycle, then m1.
        do_reset();
        step(1, 1, 0);
        step(1, 1, 1);
        chk("t2_gnt0", 64'(grant_o), 64'd1);
        step(0, 1, 0);
        chk("t2_idle", 64'(grant_o), 64'd0);
        step(0, 1, 1);
        chk("t2_gnt1", 64'(grant_o), 64'd2);

        // Burst cap with competing requests, then regrant after m1 releases.
        do_reset();
        n_ack0 = 0;
        for (int i = 0; i < 6; i++) step(1, 1, 1);
        chk("t3_acks0", 64'(n_ack0), 64'd4);
        chk("t3_gnt1", 64'(grant_o), 64'd2);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("t3_regnt0", 64'(grant_o), 64'd1);

        // Sole master keeps the grant through 20 acks.
        do_reset();
        n_ack1 = 0;
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1);
        chk("t4_acks1", 64'(n_ack1), 64'd20);
        chk("t4_gnt1", 64'(grant_o), 64'd2);

        // Asynchronous reset mid-read, then a stale ack must not be forwarded.
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        s_ack_i = 1'b1;
        do_reset();
        step(1, 0, 1);

`ifdef FLASH_ARB_TIMEOUT_EN
        do_reset();
        step(1, 0, 0);
        err_seen = 0;
        step_idx = 0;
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        chk("t6_err_at", 64'(err_seen), 64'd8);
        chk("t6_idle", 64'(grant_o), 64'd0);
        step(1, 1, 0);
        chk("t6_gnt1", 64'(grant_o), 64'd2);
`endif

        // Random traffic: masters issue short bursts and occasionally abandon.
        do_reset();
        rem0 = 0;
        rem1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rem0 == 0 && $urandom_range(3) == 0) rem0 = $urandom_range(8, 1);
            if (rem1 == 0 && $urandom_range(3) == 0) rem1 = $urandom_range(8, 1);
            if ($urandom_range(31) == 0) rem0 = 0;
            if ($urandom_range(31) == 0) rem1 = 0;
            a0 = 27'($urandom);
            a1 = 27'($urandom);
            n_ack0 = 0;
            n_ack1 = 0;
            err_seen = 0;
            step(rem0 > 0, rem1 > 0, $urandom_range(2) != 0);
            if (n_ack0 > 0 && rem0 > 0) rem0--;
            if (n_ack1 > 0 && rem1 > 0) rem1--;
            if (err_seen != 0) begin
                rem0 = 0;
                rem1 = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flash_wb_arbiter.md
Name: flash_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the shared SPI flash controller (flash_top).
- Master 0 is the boot/VRAM copy engine; master 1 is the CPU instruction/data fetch port.
- Round-robin grant, held for the whole granted cycle, with a per-grant burst cap so neither master starves the other.
- Sits in the 100 MHz flash domain, directly in front of flash_top's wb_* port.

Parameters:
- ADDR_W, 27, Wishbone address width (byte address).
- DATA_W, 32, Wishbone data width; select width is DATA_W/8.
- MAX_BURST, 16, maximum acks granted to one master while the other master is requesting; range 1..255.
- TIMEOUT_CYCLES, 4096, cycles without ack before abort; used only with FLASH_ARB_TIMEOUT_EN.

Ports:
- clk_100MHz  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_sel_i  in  DATA_W/8  master 0 byte selects
- m0_adr_i  in  ADDR_W  master 0 address
- m0_dat_i  in  DATA_W  master 0 write data
- m0_dat_o  out  DATA_W  master 0 read data
- m0_ack_o, m0_err_o  out  1 each  master 0 ack / error
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to flash_top wb_cyc_i / wb_stb_i / wb_we_i
- s_sel_o  out  DATA_W/8  to wb_sel_i
- s_adr_o  out  ADDR_W  to wb_adr_i
- s_dat_o  out  DATA_W  to wb_dat_i
- s_dat_i  in  DATA_W  from wb_dat_o
- s_ack_i  in  1  from wb_ack_o
- grant_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state IDLE, grant_o = 00, last_grant = 1 (so m0 wins the first tie).
  - Burst counter = 0, timeout counter = 0.
  - All s_* control outputs = 0; m*_ack_o = m*_err_o = 0.
- States:
  - IDLE:
    - Sample m0_cyc_i and m1_cyc_i.
    - Only one requesting: go to that master's GNT state.
    - Both requesting: grant the master != last_grant.
    - Neither: stay in IDLE.
  - GNT0 / GNT1:
    - Slave signals are a combinational mux of the granted master's signals.
    - s_cyc_o / s_stb_o are gated by grant, so they are 0 in IDLE.
  - Leaving GNTx:
    - When mx_cyc_i = 0: go to IDLE, last_grant = x.
    - Burst cap: s_ack_i arrives, burst counter reaches MAX_BURST-1, and the other master's cyc is high. Go to IDLE and set last_grant = x; the forced release takes effect the cycle after that ack.
- Latency:
  - Request in IDLE on edge N gives registered grant at edge N+1.
  - Slave sees cyc/stb in cycle N+1.
  - One IDLE dead cycle on every handover.
- Ack/data:
  - s_ack_i and s_dat_i go combinationally to the granted master only.
  - The non-granted master sees ack = 0; its dat_o carries s_dat_i but is not qualified.
  - s_ack_i seen in IDLE is ignored, with no error.
- Burst counter:
  - Increments on each s_ack_i while granted.
  - Clears on entry to IDLE.
  - Saturates and is ignored when the other master is not requesting, so a sole master keeps the grant indefinitely.
- A master dropping cyc in the same cycle as its ack: that ack is delivered, then the arbiter goes to IDLE.
- Both masters raising cyc in the same cycle from IDLE after reset: m0 is granted first.
- Reset mid-transfer: immediate return to IDLE. The slave must tolerate cyc being dropped, and flash_top is reset by the same signal.

Optional Feature:
- Macro: FLASH_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter counts cycles in GNTx while s_stb_o = 1 and s_ack_i = 0; it clears on ack or when leaving GNTx.
  - When the counter reaches TIMEOUT_CYCLES-1: mx_err_o pulses for one cycle, s_cyc_o/s_stb_o are forced to 0 for that cycle, and the FSM goes to IDLE with last_grant = x.
- Without the macro: m*_err_o are tied to 0, no counter is built, and a missing ack stalls the grant forever.

Decomposition:
- Package flash_arb_pkg holds:
  - state enum {IDLE, GNT0, GNT1};
  - localparam SEL_W = DATA_W/8;
  - the default TIMEOUT_CYCLES.
- One sub-module is natural: flash_arb_rr, the 2-way round-robin picker (inputs req[1:0], last_grant; output one-hot pick). The FSM and the muxes stay in the top module.

Test Plan:
1. Reset, then m0 alone reads 0x10000 -> grant_o = 01 one cycle after request; s_adr_o = 0x10000; m0_ack_o mirrors s_ack_i; m1_ack_o stays 0.
2. m0 and m1 both assert cyc on the same cycle after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then grant_o = 10.
3. m0 streams continuously with MAX_BURST = 4 while m1 requests -> exactly 4 m0 acks, IDLE cycle, m1 granted, then m0 regranted after m1 releases.
4. m1 alone streams 20 reads -> no forced release; 20 acks in grant 10; burst counter never forces IDLE.
5. reset_n pulsed low mid-read -> s_cyc_o = s_stb_o = 0 and grant_o = 00 immediately (no clock edge needed); a stale s_ack_i afterwards is not forwarded.
6. With FLASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never acks -> m0_err_o high for one cycle at the 8th stalled cycle; FSM in IDLE; pending m1 granted next.
